// File: rtl/culsans_domain_tagger.sv
//============================================================================
// Module   : culsans_domain_tagger (with culsans_pkg ACE channel types)
// Brief    : ACE domain/snoop tagging, registered AR/AW stage, outstanding
//            counters and per-channel shareability fence.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package culsans_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  domain;
    logic [3:0]  snoop;
    logic [1:0]  bar;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  domain;
    logic [2:0]  snoop;
    logic [1:0]  bar;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module culsans_domain_tagger #(
  parameter int unsigned                       NrRules      = 1,
  parameter int unsigned                       AddrWidth    = 64,
  parameter logic [NrRules-1:0][AddrWidth-1:0] SharedBase   = {64'h8004_0000},
  parameter logic [NrRules-1:0][AddrWidth-1:0] SharedLength = {64'h4_0000},
  parameter int unsigned                       MaxTxn       = 8,
  parameter type                               req_t        = culsans_pkg::req_t,
  parameter type                               resp_t       = culsans_pkg::resp_t
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  req_t                         slv_req_i,
  output resp_t                        slv_resp_o,
  output req_t                         mst_req_o,
  input  resp_t                        mst_resp_i,
  output logic [$clog2(MaxTxn+1)-1:0]  ar_outstanding_o,
  output logic [$clog2(MaxTxn+1)-1:0]  aw_outstanding_o,
  output logic [1:0]                   fence_stall_o
);

  localparam int unsigned c_cnt_w = $clog2(MaxTxn + 1);
  localparam int unsigned c_ar_w  = $bits(slv_req_i.ar);
  localparam int unsigned c_aw_w  = $bits(slv_req_i.aw);

  logic [AddrWidth-1:0] w_ar_addr, w_aw_addr;
  logic [NrRules-1:0]   w_ar_hit, w_aw_hit;
  logic                 w_ar_cls, w_aw_cls;
  req_t                 w_tag;

  logic [c_ar_w-1:0]    r_ar;
  logic [c_aw_w-1:0]    r_aw;
  logic                 r_ar_vld, r_aw_vld;
  logic                 r_ar_cls, r_aw_cls;
  logic [c_cnt_w-1:0]   r_ar_cnt, r_aw_cnt;

  logic w_ar_stg_rdy, w_ar_room, w_ar_fence, w_ar_rdy, w_ar_inc, w_ar_dec;
  logic w_aw_stg_rdy, w_aw_room, w_aw_fence, w_aw_rdy, w_aw_inc, w_aw_dec;

  assign w_ar_addr = AddrWidth'(slv_req_i.ar.addr);
  assign w_aw_addr = AddrWidth'(slv_req_i.aw.addr);

  // Bounds widened by one bit so a region ending at the top of the space cannot wrap.
  for (genvar gi = 0; gi < NrRules; gi++) begin : g_rule
    localparam logic [AddrWidth:0] c_lo = {1'b0, SharedBase[gi]};
    localparam logic [AddrWidth:0] c_hi = c_lo + {1'b0, SharedLength[gi]};
    localparam logic               c_en = (SharedLength[gi] != '0);

    assign w_ar_hit[gi] = c_en && ({1'b0, w_ar_addr} >= c_lo) && ({1'b0, w_ar_addr} < c_hi);
    assign w_aw_hit[gi] = c_en && ({1'b0, w_aw_addr} >= c_lo) && ({1'b0, w_aw_addr} < c_hi);
  end

  assign w_ar_cls = |w_ar_hit;
  assign w_aw_cls = |w_aw_hit;

  always_comb begin
    w_tag           = slv_req_i;
    w_tag.ar.domain = w_ar_cls ? 2'b01 : 2'b00;
    w_tag.ar.snoop  = '0;
    w_tag.ar.bar    = '0;
    w_tag.aw.domain = w_aw_cls ? 2'b01 : 2'b00;
    w_tag.aw.snoop  = '0;
    w_tag.aw.bar    = '0;
  end

  assign w_ar_stg_rdy = !r_ar_vld || mst_resp_i.ar_ready;
  assign w_ar_room    = r_ar_cnt < c_cnt_w'(MaxTxn);
  assign w_ar_fence   = (r_ar_cnt != '0) && (w_ar_cls != r_ar_cls);
  assign w_ar_rdy     = w_ar_stg_rdy && w_ar_room && !w_ar_fence;
  assign w_ar_inc     = slv_req_i.ar_valid && w_ar_rdy;
  assign w_ar_dec     = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

  assign w_aw_stg_rdy = !r_aw_vld || mst_resp_i.aw_ready;
  assign w_aw_room    = r_aw_cnt < c_cnt_w'(MaxTxn);
  assign w_aw_fence   = (r_aw_cnt != '0) && (w_aw_cls != r_aw_cls);
  assign w_aw_rdy     = w_aw_stg_rdy && w_aw_room && !w_aw_fence;
  assign w_aw_inc     = slv_req_i.aw_valid && w_aw_rdy;
  assign w_aw_dec     = mst_resp_i.b_valid && slv_req_i.b_ready;

  // A completion with nothing outstanding (e.g. a stale response after reset) is dropped.
  function automatic logic [c_cnt_w-1:0] f_cnt_next(input logic [c_cnt_w-1:0] cnt,
                                                    input logic inc, input logic dec);
    logic [c_cnt_w-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)
      nxt = cnt + c_cnt_w'(1);
    else if (dec && !inc && (cnt != '0))
      nxt = cnt - c_cnt_w'(1);
    return nxt;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ar     <= '0;
      r_aw     <= '0;
      r_ar_vld <= 1'b0;
      r_aw_vld <= 1'b0;
      r_ar_cls <= 1'b0;
      r_aw_cls <= 1'b0;
      r_ar_cnt <= '0;
      r_aw_cnt <= '0;
    end else begin
      if (w_ar_inc) begin
        r_ar     <= w_tag.ar;
        r_ar_vld <= 1'b1;
        r_ar_cls <= w_ar_cls;
      end else if (mst_resp_i.ar_ready) begin
        r_ar_vld <= 1'b0;
      end
      if (w_aw_inc) begin
        r_aw     <= w_tag.aw;
        r_aw_vld <= 1'b1;
        r_aw_cls <= w_aw_cls;
      end else if (mst_resp_i.aw_ready) begin
        r_aw_vld <= 1'b0;
      end
      r_ar_cnt <= f_cnt_next(r_ar_cnt, w_ar_inc, w_ar_dec);
      r_aw_cnt <= f_cnt_next(r_aw_cnt, w_aw_inc, w_aw_dec);
    end
  end

  always_comb begin
    mst_req_o          = w_tag;
    mst_req_o.ar       = r_ar;
    mst_req_o.ar_valid = r_ar_vld;
    mst_req_o.aw       = r_aw;
    mst_req_o.aw_valid = r_aw_vld;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = w_ar_rdy;
    slv_resp_o.aw_ready = w_aw_rdy;
  end

  assign ar_outstanding_o = r_ar_cnt;
  assign aw_outstanding_o = r_aw_cnt;
  assign fence_stall_o    = {slv_req_i.aw_valid && w_aw_stg_rdy && w_aw_room && w_aw_fence,
                             slv_req_i.ar_valid && w_ar_stg_rdy && w_ar_room && w_ar_fence};

  a_ar_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      !(w_ar_dec && (r_ar_cnt == '0)));
  a_aw_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      !(w_aw_dec && (r_aw_cnt == '0)));

endmodule

`default_nettype wire

// File: tb/tb_culsans_domain_tagger.sv
//============================================================================
// Module   : tb_culsans_domain_tagger
// Brief    : Directed scoreboard bench for culsans_domain_tagger.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_culsans_domain_tagger;
  import culsans_pkg::*;

  localparam logic [1:0][63:0] c_base = {64'hC000_0000, 64'h8004_0000};
  localparam logic [1:0][63:0] c_len  = {64'h0000_1000, 64'h0004_0000};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  req_t       slv_req;
  req_t       mst_req;
  resp_t      slv_resp;
  resp_t      mst_resp;
  logic [2:0] ar_cnt;
  logic [2:0] aw_cnt;
  logic [1:0] fence;

  int n_checks = 0;
  int n_fail   = 0;

  ar_chan_t ar_q[$];
  aw_chan_t aw_q[$];

  logic [63:0] cls_addr [6] = '{64'h8004_0000, 64'h8007_FFF8, 64'hC000_0FF8,
                                64'h8008_0000, 64'h8003_FFF8, 64'hC000_1000};
  logic        cls_sh   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  culsans_domain_tagger #(
    .NrRules      (2),
    .AddrWidth    (64),
    .SharedBase   (c_base),
    .SharedLength (c_len),
    .MaxTxn       (4),
    .req_t        (req_t),
    .resp_t       (resp_t)
  ) u_dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .ar_outstanding_o (ar_cnt),
    .aw_outstanding_o (aw_cnt),
    .fence_stall_o    (fence)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change only just after posedge, so a valid&&ready seen at
  // negedge is the handshake of the coming edge.
  always @(negedge clk) begin
    if (rst_n && mst_req.ar_valid && mst_resp.ar_ready) begin
      if (ar_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ar_unexpected: actual addr=%0h required no transfer", mst_req.ar.addr);
      end else begin
        check("ar_payload", 128'(mst_req.ar), 128'(ar_q.pop_front()));
      end
    end
    if (rst_n && mst_req.aw_valid && mst_resp.aw_ready) begin
      if (aw_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL aw_unexpected: actual addr=%0h required no transfer", mst_req.aw.addr);
      end else begin
        check("aw_payload", 128'(mst_req.aw), 128'(aw_q.pop_front()));
      end
    end
  end

  task automatic set_ar(input logic [63:0] a, input logic [3:0] id, input logic sh,
                        output ar_chan_t e);
    slv_req.ar.id     = id;
    slv_req.ar.addr   = a;
    slv_req.ar.len    = 8'h3;
    slv_req.ar.domain = 2'b11;
    slv_req.ar.snoop  = 4'hA;
    slv_req.ar.bar    = 2'b10;
    slv_req.ar_valid  = 1'b1;
    e        = slv_req.ar;
    e.domain = sh ? 2'b01 : 2'b00;
    e.snoop  = '0;
    e.bar    = '0;
  endtask

  task automatic set_aw(input logic [63:0] a, input logic [3:0] id, input logic sh,
                        output aw_chan_t e);
    slv_req.aw.id     = id;
    slv_req.aw.addr   = a;
    slv_req.aw.len    = 8'h1;
    slv_req.aw.domain = 2'b11;
    slv_req.aw.snoop  = 3'h5;
    slv_req.aw.bar    = 2'b01;
    slv_req.aw_valid  = 1'b1;
    e        = slv_req.aw;
    e.domain = sh ? 2'b01 : 2'b00;
    e.snoop  = '0;
    e.bar    = '0;
  endtask

  // Called and returning at posedge+1; returns right after the accepting edge.
  task automatic issue_ar(input logic [63:0] a, input logic [3:0] id, input logic sh,
                          input logic last, output int waited, output ar_chan_t e);
    set_ar(a, id, sh, e);
    #1;
    waited = 0;
    while (!slv_resp.ar_ready && waited < 40) begin
      @(posedge clk); #2;
      waited++;
    end
    check("ar_accept", 128'(slv_resp.ar_ready), 128'(1));
    ar_q.push_back(e);
    @(posedge clk); #1;
    if (last) slv_req.ar_valid = 1'b0;
  endtask

  task automatic issue_aw(input logic [63:0] a, input logic [3:0] id, input logic sh,
                          output aw_chan_t e);
    int waited;
    set_aw(a, id, sh, e);
    #1;
    waited = 0;
    while (!slv_resp.aw_ready && waited < 40) begin
      @(posedge clk); #2;
      waited++;
    end
    check("aw_accept", 128'(slv_resp.aw_ready), 128'(1));
    aw_q.push_back(e);
    @(posedge clk); #1;
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic r_last();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    mst_resp.r.id    = 4'h1;
    @(posedge clk); #1;
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
  endtask

  task automatic b_pulse();
    mst_resp.b_valid = 1'b1;
    @(posedge clk); #1;
    mst_resp.b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ar_chan_t e_a;
    ar_chan_t e_b;
    aw_chan_t ew;
    int       waited;

    slv_req           = '0;
    mst_resp          = '0;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;

    // Reset values
    #12;
    check("rst_ar_valid", 128'(mst_req.ar_valid), 128'(0));
    check("rst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
    check("rst_ar_cnt",   128'(ar_cnt), 128'(0));
    check("rst_aw_cnt",   128'(aw_cnt), 128'(0));
    check("rst_fence",    128'(fence),  128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Classification, including both edges of each rule
    for (int i = 0; i < 6; i++) begin
      issue_ar(cls_addr[i], 4'(i), cls_sh[i], 1'b1, waited, e_a);
      check("cls_mst_valid", 128'(mst_req.ar_valid), 128'(1));
      check("cls_domain",    128'(mst_req.ar.domain), 128'(cls_sh[i] ? 2'b01 : 2'b00));
      check("cls_snoop",     128'(mst_req.ar.snoop), 128'(0));
      check("cls_count",     128'(ar_cnt), 128'(1));
      r_last();
    end
    check("cls_drained", 128'(ar_cnt), 128'(0));

    // Back-to-back until full
    for (int i = 0; i < 4; i++) begin
      issue_ar(64'h8004_0100 + 64'(i * 8), 4'(i), 1'b1, 1'b0, waited, e_a);
      check("b2b_no_wait", 128'(waited), 128'(0));
      check("b2b_count",   128'(ar_cnt), 128'(i + 1));
    end
    set_ar(64'h8004_0200, 4'd4, 1'b1, e_a);
    #1;
    check("full_ready0", 128'(slv_resp.ar_ready), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("full_ready1", 128'(slv_resp.ar_ready), 128'(0));
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    #1;
    check("full_ready_on_r", 128'(slv_resp.ar_ready), 128'(0));
    @(posedge clk); #1;
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    check("full_count_after_r", 128'(ar_cnt), 128'(3));
    check("full_ready_back", 128'(slv_resp.ar_ready), 128'(1));
    ar_q.push_back(e_a);
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    check("full_refill", 128'(ar_cnt), 128'(4));
    repeat (4) r_last();
    check("full_drained", 128'(ar_cnt), 128'(0));

    // Accept and R last in the same cycle
    issue_ar(64'h8004_0300, 4'd5, 1'b1, 1'b0, waited, e_a);
    issue_ar(64'h8004_0308, 4'd6, 1'b1, 1'b1, waited, e_a);
    check("sim_pre", 128'(ar_cnt), 128'(2));
    set_ar(64'h8004_0310, 4'd7, 1'b1, e_a);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    #1;
    check("sim_ready", 128'(slv_resp.ar_ready), 128'(1));
    ar_q.push_back(e_a);
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    check("sim_count", 128'(ar_cnt), 128'(2));
    repeat (2) r_last();

    // Backpressure on the master AR port
    mst_resp.ar_ready = 1'b0;
    issue_ar(64'h8004_0400, 4'd8, 1'b1, 1'b1, waited, e_a);
    set_ar(64'h8004_0408, 4'd9, 1'b1, e_b);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_slv_ready", 128'(slv_resp.ar_ready), 128'(0));
      check("bp_mst_valid", 128'(mst_req.ar_valid), 128'(1));
      check("bp_stable",    128'(mst_req.ar), 128'(e_a));
      @(posedge clk); #1;
    end
    mst_resp.ar_ready = 1'b1;
    #1;
    check("bp_release_ready", 128'(slv_resp.ar_ready), 128'(1));
    ar_q.push_back(e_b);
    @(posedge clk); #1;
    slv_req.ar_valid = 1'b0;
    check("bp_count", 128'(ar_cnt), 128'(2));
    @(posedge clk); #1;
    check("bp_no_loss", 128'(ar_q.size()), 128'(0));
    repeat (2) r_last();

    // Shareability fence on AW, plus W/B pass-through
    issue_aw(64'h8004_1000, 4'd1, 1'b1, ew);
    check("fence_pre_count", 128'(aw_cnt), 128'(1));
    set_aw(64'h0000_2000, 4'd2, 1'b0, ew);
    slv_req.w_valid = 1'b1;
    #1;
    check("fence_stall",    128'(fence), 128'(2'b10));
    check("fence_aw_ready", 128'(slv_resp.aw_ready), 128'(0));
    check("w_valid_pass",   128'(mst_req.w_valid), 128'(1));
    check("w_ready_pass",   128'(slv_resp.w_ready), 128'(1));
    @(posedge clk); #1;
    slv_req.w_valid  = 1'b0;
    mst_resp.b_valid = 1'b1;
    #1;
    check("fence_hold",   128'(fence), 128'(2'b10));
    check("b_valid_pass", 128'(slv_resp.b_valid), 128'(1));
    @(posedge clk); #1;
    mst_resp.b_valid = 1'b0;
    #1;
    check("fence_release", 128'(slv_resp.aw_ready), 128'(1));
    check("fence_clear",   128'(fence), 128'(0));
    aw_q.push_back(ew);
    @(posedge clk); #1;
    slv_req.aw_valid = 1'b0;
    check("fence_accept_count", 128'(aw_cnt), 128'(1));
    check("fence_domain",       128'(mst_req.aw.domain), 128'(2'b00));
    b_pulse();
    check("fence_drained", 128'(aw_cnt), 128'(0));

    // Asynchronous reset with count 3 and the stage full
    issue_ar(64'h8004_0500, 4'd10, 1'b1, 1'b0, waited, e_a);
    issue_ar(64'h8004_0508, 4'd11, 1'b1, 1'b1, waited, e_a);
    @(posedge clk); #1;
    mst_resp.ar_ready = 1'b0;
    issue_ar(64'h8004_0510, 4'd12, 1'b1, 1'b1, waited, e_a);
    check("rst_pre_count", 128'(ar_cnt), 128'(3));
    check("rst_pre_valid", 128'(mst_req.ar_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ar_valid", 128'(mst_req.ar_valid), 128'(0));
    check("arst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
    check("arst_ar_cnt",   128'(ar_cnt), 128'(0));
    check("arst_aw_cnt",   128'(aw_cnt), 128'(0));
    check("arst_fence",    128'(fence),  128'(0));
    ar_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mst_resp.ar_ready = 1'b1;
    issue_ar(64'h0000_1000, 4'd13, 1'b0, 1'b1, waited, e_a);
    check("post_rst_wait",  128'(waited), 128'(0));
    check("post_rst_count", 128'(ar_cnt), 128'(1));
    check("post_rst_valid", 128'(mst_req.ar_valid), 128'(1));
    r_last();
    @(posedge clk); #1;
    check("end_ar_cnt",  128'(ar_cnt), 128'(0));
    check("end_ar_q",    128'(ar_q.size()), 128'(0));
    check("end_aw_q",    128'(aw_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
